// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and duty clamp helper for the PWM ramp scheduler.
// Pure declarations: no latency, no flow control.
package pwm_pkg;

  localparam int DUTY_W        = 4;
  localparam int DUTY_MAX_DFLT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] lim
  );
    return (duty > lim) ? lim : duty;
  endfunction

endpackage

// File: rtl/pwm_rr_pick.sv
// Round-robin pick of the first requesting channel at or after rr_ptr (wrapping).
// Purely combinational, zero latency; no flow control.
module pwm_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    grant   = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // rr_ptr < NUM_CH and i < NUM_CH, so one subtraction is enough to wrap
      sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      idx = sum[CH_W-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Ramps per-channel PWM duty one code per tick toward commanded targets, round-robin across channels.
// Target written 1 cycle after accept; cmd_ready drops for one cycle after each accept; duty_o updates only on period_start.
module pwm_ramp_scheduler
  import pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DUTY_MAX = DUTY_MAX_DFLT,
  parameter int TICK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0]  cmd_ch,
  input  logic [DUTY_W-1:0]          cmd_duty,
  input  logic                       period_start,
  output logic [NUM_CH*DUTY_W-1:0]   duty_o,
  output logic                       busy,
  output logic                       done
);

  localparam int                CH_W = $clog2(NUM_CH);
  localparam int                PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DRST = DUTY_W'(DUTY_MAX / 2);

  logic                    rdy_q;
  logic                    accept;
  logic                    cmd_pend;
  logic [CH_W-1:0]         cmd_ch_q;
  logic [DUTY_W-1:0]       cmd_duty_q;

  logic [PS_W-1:0]         presc;
  logic                    tick;

  logic [DUTY_W-1:0]       target  [NUM_CH];
  logic [DUTY_W-1:0]       working [NUM_CH];
  logic [NUM_CH*DUTY_W-1:0] duty_q;
  logic [NUM_CH-1:0]       off_tgt;

  logic [CH_W-1:0]         rr_ptr;
  logic [CH_W-1:0]         grant;
  logic                    any_req;

  ramp_state_t             state;
  ramp_state_t             state_nxt;
  logic                    step_en;

  // One-entry command register; ready is low in the cycle the entry is occupied
  assign accept    = cmd_valid & rdy_q;
  assign cmd_ready = rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      cmd_pend   <= 1'b0;
      cmd_ch_q   <= '0;
      cmd_duty_q <= '0;
    end else begin
      rdy_q    <= !accept;
      cmd_pend <= accept;
      if (accept) begin
        cmd_ch_q   <= cmd_ch;
        cmd_duty_q <= cmd_duty;
      end
    end
  end

  assign tick = (presc == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PS_W'(1);
    end
  end

  always_comb begin
    off_tgt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      off_tgt[k] = (working[k] != target[k]);
    end
  end

  pwm_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req     (off_tgt),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_en   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          if (any_req) begin
            step_en = 1'b1;
          end else begin
            state_nxt = IDLE;
            done      = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RAMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (step_en) begin
      rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        target[k] <= DRST;
      end
    end else if (cmd_pend) begin
      target[cmd_ch_q] <= clamp_duty(cmd_duty_q, DMAX);
    end
  end

  // Direction comes from the registered target, so a same-cycle retarget only affects later steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        working[k] <= DRST;
      end
    end else if (step_en) begin
      if (working[grant] < target[grant]) begin
        working[grant] <= working[grant] + DUTY_W'(1);
      end else begin
        working[grant] <= working[grant] - DUTY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= {NUM_CH{DRST}};
    end else if (period_start) begin
      for (int k = 0; k < NUM_CH; k++) begin
        duty_q[k*DUTY_W +: DUTY_W] <= working[k];
      end
    end
  end

  assign duty_o = duty_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Directed bench for pwm_ramp_scheduler: vector table plus hand-written ramp, round-robin,
// clamp, retarget and mid-ramp reset sequences against hand-computed expectations.
module tb_pwm_ramp_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [3:0]  cmd_duty;
  logic        period_start;
  logic [15:0] duty_o;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pwm_ramp_scheduler #(
    .NUM_CH   (4),
    .DUTY_MAX (10),
    .TICK_DIV (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ch       (cmd_ch),
    .cmd_duty     (cmd_duty),
    .period_start (period_start),
    .duty_o       (duty_o),
    .busy         (busy),
    .done         (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: logs every duty_o channel change, counts done pulses
  typedef struct {
    int   cyc;
    int   ch;
    int   val;
    logic bsy;
  } ev_t;

  ev_t         evq[$];
  int          cyc       = 0;
  int          done_cnt  = 0;
  logic        prev_busy = 1'b0;
  logic [15:0] prev_duty = 16'h5555;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && prev_busy !== 1'b1) check("done_at_busy_rise", done, 0);
      for (int k = 0; k < 4; k++) begin
        if (duty_o[4*k +: 4] !== prev_duty[4*k +: 4]) begin
          evq.push_back('{cyc, k, int'(duty_o[4*k +: 4]), busy});
        end
      end
      prev_busy = busy;
      prev_duty = duty_o;
    end
  end

  // period_start generator: 0 = off, 1 = every cycle, 2 = every 10 cycles
  int ps_mode = 0;
  int ps_cnt  = 0;

  initial begin
    period_start = 1'b0;
    forever begin
      @(negedge clk);
      ps_cnt++;
      case (ps_mode)
        1:       period_start = 1'b1;
        2:       period_start = (ps_cnt % 10 == 0);
        default: period_start = 1'b0;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input int ch, input int duty);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_ready_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_ch    = ch[1:0];
    cmd_duty  = duty[3:0];
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int n;
    start = done_cnt;
    n     = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done_cnt == start) begin
      bad++;
      $display("FAIL %s: no done pulse within %0d cycles, want one", name, budget);
    end
  endtask

  task automatic wait_val(input string name, input int ch, input int val, input int budget);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      foreach (evq[i]) if (evq[i].ch == ch && evq[i].val == val) found = 1'b1;
      if (!found) begin
        @(negedge clk);
        n++;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: ch%0d never showed %0d within %0d cycles", name, ch, val, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          ch;
    int          duty;
    logic        exp_done;
    logic [15:0] exp_duty;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [5:0] pat;
    int         acc;
    int         start;
    int         errs;
    int         maxv;
    int         exp_ch[4];
    int         exp_val[4];

    vt[0] = '{0,  8, 1'b1, 16'h5558};
    vt[1] = '{3, 15, 1'b1, 16'hA558};
    vt[2] = '{1,  0, 1'b1, 16'hA508};
    vt[3] = '{2, 10, 1'b1, 16'hAA08};
    vt[4] = '{3,  3, 1'b1, 16'h3A08};
    vt[5] = '{0, 12, 1'b1, 16'h3A0A};
    vt[6] = '{1,  5, 1'b1, 16'h3A5A};
    vt[7] = '{2,  5, 1'b1, 16'h355A};
    vt[8] = '{0, 15, 1'b0, 16'h355A};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_duty  = '0;

    // Reset state
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_duty_o", duty_o, 16'h5555);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Handshake: valid held for 6 cycles, same target as current so no ramp
    acc       = 0;
    cmd_valid = 1'b1;
    cmd_ch    = 2'd1;
    cmd_duty  = 4'd5;
    for (int i = 0; i < 6; i++) begin
      pat[5-i] = cmd_ready;
      if (cmd_ready === 1'b1) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("hs_ready_pattern", pat, 6'b101010);
    check("hs_accepts", acc, 3);
    repeat (6) @(negedge clk);
    check("hs_no_ramp", busy, 0);

    // Vector table with period_start every 10 cycles
    ps_mode = 2;
    for (int v = 0; v < 9; v++) begin
      start = done_cnt;
      send(vt[v].ch, vt[v].duty);
      if (vt[v].exp_done) begin
        wait_done($sformatf("vec%0d_done", v), 80);
      end else begin
        repeat (20) @(negedge clk);
        check($sformatf("vec%0d_no_done", v), done_cnt - start, 0);
        check($sformatf("vec%0d_idle", v), busy, 0);
      end
      repeat (12) @(negedge clk);
      check($sformatf("vec%0d_duty_o", v), duty_o, vt[v].exp_duty);
    end

    // Ramp up ch0 5->8 with period_start every cycle so duty_o tracks working
    do_reset();
    @(negedge clk);
    check("rst2_duty_o", duty_o, 16'h5555);
    ps_mode = 1;
    repeat (2) @(negedge clk);
    evq.delete();
    start = done_cnt;
    send(0, 8);
    wait_done("ramp_up_done", 60);
    repeat (8) @(negedge clk);
    check("ramp_up_steps", evq.size(), 3);
    if (evq.size() == 3) begin
      check("ramp_up_v0", evq[0].val, 6);
      check("ramp_up_v1", evq[1].val, 7);
      check("ramp_up_v2", evq[2].val, 8);
      check("ramp_up_gap0", evq[1].cyc - evq[0].cyc, 4);
      check("ramp_up_gap1", evq[2].cyc - evq[1].cyc, 4);
    end
    check("ramp_up_done_cnt", done_cnt - start, 1);
    check("ramp_up_duty0", duty_o[3:0], 8);

    // Round-robin: ch1 5->7 and ch2 5->3 interleave
    exp_ch  = '{1, 2, 1, 2};
    exp_val = '{6, 4, 7, 3};
    evq.delete();
    start = done_cnt;
    send(1, 7);
    send(2, 3);
    wait_done("rr_done", 80);
    repeat (4) @(negedge clk);
    check("rr_steps", evq.size(), 4);
    if (evq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr_ch%0d", i), evq[i].ch, exp_ch[i]);
        check($sformatf("rr_val%0d", i), evq[i].val, exp_val[i]);
        check($sformatf("rr_busy%0d", i), evq[i].bsy, 1);
      end
    end
    check("rr_done_cnt", done_cnt - start, 1);

    // Clamp up to DUTY_MAX then ramp all the way to 0
    evq.delete();
    send(3, 15);
    wait_done("clamp_up_done", 80);
    repeat (4) @(negedge clk);
    maxv = 0;
    foreach (evq[i]) if (evq[i].val > maxv) maxv = evq[i].val;
    check("clamp_up_steps", evq.size(), 5);
    check("clamp_up_max", maxv, 10);
    check("clamp_up_duty3", duty_o[15:12], 10);
    evq.delete();
    send(3, 0);
    wait_done("clamp_down_done", 80);
    repeat (4) @(negedge clk);
    errs = 0;
    foreach (evq[i]) if (evq[i].ch != 3 || evq[i].val != 9 - i) errs++;
    check("clamp_down_steps", evq.size(), 10);
    check("clamp_down_seq_errs", errs, 0);
    check("clamp_down_duty3", duty_o[15:12], 0);

    // Retarget ch0 mid-ramp: 5 -> 9, then 6 once working reaches 7
    send(0, 5);
    wait_done("retgt_pre_done", 60);
    repeat (4) @(negedge clk);
    evq.delete();
    start = done_cnt;
    send(0, 9);
    wait_val("retgt_reach7", 0, 7, 60);
    check("retgt_no_early_done", done_cnt - start, 0);
    send(0, 6);
    wait_done("retgt_done", 60);
    repeat (4) @(negedge clk);
    maxv = 0;
    foreach (evq[i]) if (evq[i].val > maxv) maxv = evq[i].val;
    check("retgt_overshoot_max", (maxv <= 8), 1);
    check("retgt_final", evq.size() > 0 ? evq[evq.size()-1].val : -1, 6);
    check("retgt_done_cnt", done_cnt - start, 1);
    check("retgt_duty0", duty_o[3:0], 6);

    // Reset mid-ramp with a command captured but not yet applied
    evq.delete();
    send(0, 9);
    wait_val("rstmid_reach7", 0, 7, 60);
    cmd_valid = 1'b1;
    cmd_ch    = 2'd2;
    cmd_duty  = 4'd0;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rstmid_duty_o", duty_o, 16'h5555);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = done_cnt;
    @(negedge clk);
    check("rstmid_ready_after", cmd_ready, 1);
    check("rstmid_busy_after", busy, 0);
    repeat (20) @(negedge clk);
    check("rstmid_no_ramp", busy, 0);
    check("rstmid_pending_dropped", duty_o, 16'h5555);
    check("rstmid_no_done", done_cnt - start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_scheduler.md
PWM_RAMP_SCHEDULER -- requirements
Module: pwm_ramp_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of PWM channels scheduled.
REQ-002 The block SHALL have parameter DUTY_MAX, default 10: maximum duty code, in 10 % steps.
REQ-003 The block SHALL have parameter TICK_DIV, default 4: clk cycles per ramp tick, minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a target-duty command is offered.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have port cmd_ch, input, $clog2(NUM_CH) bits: the channel the command addresses.
REQ-009 The block SHALL have port cmd_duty, input, 4 bits: the requested target duty code.
REQ-010 The block SHALL have port period_start, input, 1 bit: one-cycle pulse marking a PWM period boundary.
REQ-011 The block SHALL have port duty_o, output, NUM_CH*4 bits: active duty per channel, with channel k at [4k+3:4k].
REQ-012 The block SHALL have port busy, output, 1 bit: the FSM is in state RAMP.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when every channel reaches its target.

Function
REQ-014 A command SHALL be accepted on a rising clk edge where cmd_valid=1 and cmd_ready=1; cmd_ch and cmd_duty SHALL then be captured into a one-entry command register.
REQ-015 cmd_ready SHALL be 0 in the cycle after an acceptance and 1 otherwise, so back-to-back commands are accepted at most every second cycle.
REQ-016 A captured command SHALL write target[cmd_ch] one cycle after acceptance, with cmd_duty values above DUTY_MAX clamped to DUTY_MAX.
REQ-017 The ramp prescaler SHALL count 0..TICK_DIV-1 continuously from reset and wrap to 0; tick SHALL be 1 in cycles where the count is TICK_DIV-1.
REQ-018 The FSM SHALL have exactly two states, IDLE and RAMP.
REQ-019 The FSM SHALL go from IDLE to RAMP in the cycle after any working[k] differs from target[k].
REQ-020 In RAMP, on each tick, the block SHALL search channels starting at rr_ptr, ascending and wrapping, and select the first channel with working != target.
REQ-021 The selected channel's working duty SHALL move exactly 1 code toward its target, and rr_ptr SHALL become (selected+1) mod NUM_CH.
REQ-022 If no channel is off-target on a tick in RAMP, the FSM SHALL go to IDLE, pulse done for one cycle, and leave rr_ptr unchanged.
REQ-023 At most one channel SHALL step per tick, and no channel SHALL step while the FSM is in IDLE.
REQ-024 The step direction SHALL be computed from target values registered before the current edge; if a target write and a step hit the same channel in one cycle, the new target SHALL take effect and the step SHALL still use the old target.
REQ-025 working values SHALL stay within 0..DUTY_MAX at all times, with no wrap-around below 0 or above DUTY_MAX.
REQ-026 On each period_start pulse, duty_o SHALL load all working values simultaneously; between pulses duty_o SHALL hold, so no mid-period glitch reaches the PWM generators.
REQ-027 A step and a period_start in the same cycle SHALL give duty_o the pre-step working value; the stepped value SHALL appear at the next period_start.
REQ-028 busy SHALL equal (state==RAMP), and done SHALL never be asserted in the same cycle as busy rising.

Reset
REQ-029 While rst=1, asynchronously: cmd_ready=0, busy=0, done=0, state=IDLE, rr_ptr=0, prescaler=0, the command register SHALL be empty, and every target, working and duty_o channel SHALL be DUTY_MAX/2 (5).
REQ-030 cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-ramp SHALL abort the ramp, discard any pending command, and restore all REQ-029 values without waiting for a clock edge.

Structure
REQ-032 Shared package pwm_pkg SHALL hold the DUTY_W=4 constant, the DUTY_MAX default, and the FSM state enumeration ramp_state_t.
REQ-033 The round-robin off-target search SHALL be one combinational sub-module, pwm_rr_pick, with inputs request mask and rr_ptr and outputs grant index and any_req.
REQ-034 Everything else SHALL be implemented in pwm_ramp_scheduler, with no further hierarchy.

Verification
REQ-035 Ramp up: after reset, command ch0=8 with period_start every 10 cycles -> working0 goes 5,6,7,8 on three successive ticks (4 cycles apart); done pulses once; duty_o[3:0] reads 8 after the next period_start.
REQ-036 Round-robin: commands ch1=7 and ch2=3 -> steps alternate ch1,ch2,ch1,ch2; done pulses after the 4th step; busy is high throughout the ramp.
REQ-037 Clamp and limits: command ch3=15 -> target3=10, working3 stops at 10; then command ch3=0 -> working3 ramps down to 0 and never underflows.
REQ-038 Handshake: cmd_valid held high for 6 cycles -> exactly 3 acceptances; cmd_ready pattern 1,0,1,0,1,0.
REQ-039 Retarget: command ch0=9; while working0=7, command ch0=6 -> working0 moves 7,6 at most one step late; no done pulse before working0 reaches 6.
REQ-040 Reset mid-ramp: assert rst during the ch0 ramp 5->9 -> all outputs return to reset values immediately; after release, cmd_ready=1 and busy=0.
